// File: rtl/rsa256_uart_wrapper.sv
// rsa256_uart_wrapper: Avalon-MM master that polls an RS232 UART, loads N/D/A into the RSA-256 core and returns plaintext bytes.
// Optional macro RSA_KEY_RELOAD_EN: an all-ones cipher block clears the key instead of being decrypted.
module rsa256_uart_wrapper #(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6,
    parameter int         IN_BYTES    = 32,
    parameter int         OUT_BYTES   = 31
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_rsa_start,
    output logic [255:0] o_rsa_a,
    output logic [255:0] o_rsa_d,
    output logic [255:0] o_rsa_n,
    input  logic [255:0] i_rsa_result,
    input  logic         i_rsa_finished,
    output logic [2:0]   o_dbg_state
);

    typedef enum logic [2:0] {
        S_RX_POLL    = 3'd0,
        S_RX_READ    = 3'd1,
        S_CALC_START = 3'd2,
        S_CALC_WAIT  = 3'd3,
        S_TX_POLL    = 3'd4,
        S_TX_WRITE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        F_N = 2'd0,
        F_D = 2'd1,
        F_A = 2'd2
    } field_t;

    localparam logic [5:0] LAST_IN  = 6'(IN_BYTES - 1);
    localparam logic [5:0] LAST_OUT = 6'(OUT_BYTES - 1);

    state_t         state, state_nx;
    field_t         field;
    logic [5:0]     cnt;
    logic [255:0]   n_r, d_r, a_r, result_r;
    logic [255:0]   a_shift;
    logic           rx_last, tx_last, key_reload;
    logic           unused_rdata;

    assign o_rsa_n      = n_r;
    assign o_rsa_d      = d_r;
    assign o_rsa_a      = a_r;
    assign o_dbg_state  = state;
    assign unused_rdata = ^avm_readdata[31:8];

    assign rx_last = (cnt == LAST_IN);
    assign tx_last = (cnt == LAST_OUT);
    assign a_shift = {a_r[247:0], avm_readdata[7:0]};

`ifdef RSA_KEY_RELOAD_EN
    assign key_reload = (field == F_A) && rx_last && (&a_shift);
`else
    assign key_reload = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_RX_POLL;
        else          state <= state_nx;
    end

    // Avalon handshake: a request (read or write, never both) is driven purely from
    // state and registers, so it cannot change while avm_waitrequest=1; the transfer
    // completes, and readdata is sampled, in the first cycle with avm_waitrequest=0.
    always_comb begin
        state_nx      = state;
        avm_address   = STATUS_BASE;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = {24'd0, result_r[247:240]};
        o_rsa_start   = 1'b0;
        case (state)
            S_RX_POLL: begin
                avm_read = 1'b1;
                if (!avm_waitrequest && avm_readdata[RX_OK_BIT]) state_nx = S_RX_READ;
            end
            S_RX_READ: begin
                avm_read    = 1'b1;
                avm_address = RX_BASE;
                if (!avm_waitrequest) begin
                    if (field == F_A && rx_last && !key_reload) state_nx = S_CALC_START;
                    else                                         state_nx = S_RX_POLL;
                end
            end
            S_CALC_START: begin
                o_rsa_start = 1'b1;
                state_nx    = S_CALC_WAIT;
            end
            S_CALC_WAIT: begin
                if (i_rsa_finished) state_nx = S_TX_POLL;
            end
            S_TX_POLL: begin
                avm_read = 1'b1;
                if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) state_nx = S_TX_WRITE;
            end
            S_TX_WRITE: begin
                avm_write   = 1'b1;
                avm_address = TX_BASE;
                if (!avm_waitrequest) state_nx = tx_last ? S_RX_POLL : S_TX_POLL;
            end
            default: state_nx = S_RX_POLL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            n_r      <= '0;
            d_r      <= '0;
            a_r      <= '0;
            result_r <= '0;
            cnt      <= '0;
            field    <= F_N;
        end else begin
            case (state)
                S_RX_READ: begin
                    if (!avm_waitrequest) begin
                        case (field)
                            F_N:     n_r <= {n_r[247:0], avm_readdata[7:0]};
                            F_D:     d_r <= {d_r[247:0], avm_readdata[7:0]};
                            default: a_r <= a_shift;
                        endcase
                        if (rx_last) begin
                            cnt <= '0;
                            case (field)
                                F_N:     field <= F_D;
                                default: field <= F_A;
                            endcase
                            // Reload request: forget the key entirely, the next bytes are a new N.
                            if (key_reload) begin
                                n_r   <= '0;
                                d_r   <= '0;
                                a_r   <= '0;
                                field <= F_N;
                            end
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                S_CALC_WAIT: begin
                    if (i_rsa_finished) begin
                        result_r <= i_rsa_result;
                        cnt      <= '0;
                    end
                end
                S_TX_WRITE: begin
                    if (!avm_waitrequest) begin
                        result_r <= result_r << 8;
                        if (tx_last) begin
                            cnt   <= '0;
                            field <= F_A;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// Bench for rsa256_uart_wrapper: UART slave model, RSA core stub with plain-arithmetic modexp, TX byte scoreboard.
// Define RSA_KEY_RELOAD_EN for both files to exercise the key-reload variant.
module tb_rsa256_uart_wrapper;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         o_rsa_start;
    logic [255:0] o_rsa_a, o_rsa_d, o_rsa_n;
    logic [255:0] i_rsa_result;
    logic         i_rsa_finished;
    logic [2:0]   o_dbg_state;

    rsa256_uart_wrapper dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_rsa_start     (o_rsa_start),
        .o_rsa_a         (o_rsa_a),
        .o_rsa_d         (o_rsa_d),
        .o_rsa_n         (o_rsa_n),
        .i_rsa_result    (i_rsa_result),
        .i_rsa_finished  (i_rsa_finished),
        .o_dbg_state     (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned modexp(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r;
        if (m == 0) return 0;
        r = 1 % m;
        b = b % m;
        while (e != 0) begin
            if ((e & 1) != 0) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned reduce256(input logic [255:0] v, input longint unsigned m);
        longint unsigned r = 0;
        if (m == 0) return 0;
        for (int i = 31; i >= 0; i--) r = (r * 256 + longint'(v[i*8 +: 8])) % m;
        return r;
    endfunction

    // UART slave model
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          rx_cnt = 0;
    int          tx_cnt = 0;
    int          wait_cycles = 0;
    bit          rand_status = 1'b0;
    int          stall_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [4:0]  prev_addr;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_wd;

    initial begin
        logic [31:0] tmp;
        bit rx_ok, tx_ok;
        avm_waitrequest = 1'b1;
        avm_readdata    = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                stall_cnt       = 0;
                prev_stall      = 1'b0;
                avm_waitrequest = 1'b1;
            end else begin
                if (avm_read && avm_write) check("rd_wr_excl", 1, 0);
                if (prev_stall) begin
                    check("stall_addr", avm_address, prev_addr);
                    check("stall_rd", avm_read, prev_rd);
                    check("stall_wr", avm_write, prev_wr);
                    if (prev_wr) check("stall_wdata", avm_writedata, prev_wd);
                end
                if (avm_read || avm_write) begin
                    tmp = $urandom();
                    if (stall_cnt < wait_cycles) begin
                        avm_waitrequest = 1'b1;
                        avm_readdata    = tmp;
                        stall_cnt++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        stall_cnt       = 0;
                        if (avm_read && avm_address == 5'd8) begin
                            rx_ok = (rx_q.size() > 0) && (!rand_status || ($urandom_range(0, 1) == 1));
                            tx_ok = !rand_status || ($urandom_range(0, 1) == 1);
                            avm_readdata = (tmp & ~32'hC0) | {24'd0, rx_ok, tx_ok, 6'd0};
                        end else if (avm_read && avm_address == 5'd0) begin
                            if (rx_q.size() == 0) begin
                                check("rx_underflow", 1, 0);
                                avm_readdata = tmp;
                            end else begin
                                avm_readdata = {tmp[31:8], rx_q.pop_front()};
                            end
                            rx_cnt++;
                        end else if (avm_read) begin
                            check("rd_addr", avm_address, 5'd8);
                        end else begin
                            check("wr_addr", avm_address, 5'd4);
                            check("wr_hi_zero", avm_writedata[31:8], 0);
                            tx_cnt++;
                            if (exp_q.size() == 0) check("tx_extra_byte", avm_writedata[7:0], 256'h100);
                            else check("tx_byte", avm_writedata[7:0], exp_q.pop_front());
                        end
                    end
                    prev_stall = avm_waitrequest;
                    prev_addr  = avm_address;
                    prev_rd    = avm_read;
                    prev_wr    = avm_write;
                    prev_wd    = avm_writedata;
                end else begin
                    avm_waitrequest = 1'b0;
                    prev_stall      = 1'b0;
                end
            end
        end
    end

    // RSA core stub: computes a^d mod n from its inputs and leaves garbage in bits 255:248.
    int           core_delay = 3;
    int           start_cnt = 0;
    int           rx_at_start = 0;
    bit           spur_req = 1'b0;
    logic [255:0] snap_n, snap_d, snap_a;

    initial begin
        longint unsigned res;
        i_rsa_finished = 1'b0;
        i_rsa_result   = '0;
        forever begin
            @(negedge i_clk);
            if (o_rsa_start === 1'b1) begin
                start_cnt++;
                snap_n      = o_rsa_n;
                snap_d      = o_rsa_d;
                snap_a      = o_rsa_a;
                rx_at_start = rx_cnt;
                res = modexp(reduce256(snap_a, longint'(snap_n[31:0])), longint'(snap_d[31:0]),
                             longint'(snap_n[31:0]));
                repeat (core_delay) @(negedge i_clk);
                i_rsa_result   = {8'hA5, 248'(res)};
                i_rsa_finished = 1'b1;
                @(negedge i_clk);
                i_rsa_finished = 1'b0;
                i_rsa_result   = {$urandom(), 224'd0};
            end else if (spur_req) begin
                i_rsa_result   = {8'h5A, 248'h1234_5678};
                i_rsa_finished = 1'b1;
                @(negedge i_clk);
                i_rsa_finished = 1'b0;
                spur_req       = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic push_field(input logic [255:0] v);
        for (int i = 31; i >= 0; i--) rx_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic push_exp(input longint unsigned r);
        logic [247:0] e;
        e = 248'(r);
        for (int i = 30; i >= 0; i--) exp_q.push_back(e[i*8 +: 8]);
    endtask

    task automatic run_block(input bit do_rst, input bit send_key, input bit spur,
                             input longint unsigned n, input longint unsigned d,
                             input logic [255:0] a, input longint unsigned res);
        int s0, t0, nbytes, cyc;
        if (do_rst) do_reset();
        if (spur) begin
            spur_req = 1'b1;
            cyc = 0;
            while (spur_req && cyc < 100) begin @(negedge i_clk); cyc++; end
            check("spur_done", spur_req, 0);
            repeat (3) @(negedge i_clk);
        end
        s0 = start_cnt;
        t0 = tx_cnt;
        if (send_key) begin
            push_field(256'(n));
            push_field(256'(d));
        end
        push_field(a);
        push_exp(res);
        nbytes = rx_cnt + rx_q.size();
        cyc = 0;
        while ((tx_cnt - t0) < 31 && cyc < 30000) begin @(negedge i_clk); cyc++; end
        repeat (20) @(negedge i_clk);
        check("tx_count", tx_cnt - t0, 31);
        check("start_count", start_cnt - s0, 1);
        check("rx_at_start", rx_at_start, nbytes);
        check("core_n", snap_n, 256'(n));
        check("core_d", snap_d, 256'(d));
        check("core_a", snap_a, a);
        check("exp_drained", exp_q.size(), 0);
    endtask

    typedef struct {
        bit              do_rst;
        bit              send_key;
        bit              spur;
        longint unsigned n;
        longint unsigned d;
        longint unsigned a;
        longint unsigned res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int s0, t0, cyc;
        longint unsigned rn, rd, ra;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 33, 7, 2, 29};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 33, 7, 5, 14};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 35, 5, 3, 33};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 35, 5, 4, 9};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 187, 3, 10, 65};

        // reset values
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_read", avm_read, 1);
        check("rst_addr", avm_address, 8);
        check("rst_write", avm_write, 0);
        check("rst_start", o_rsa_start, 0);
        check("rst_n", o_rsa_n, 0);
        check("rst_d", o_rsa_d, 0);
        check("rst_a", o_rsa_a, 0);
        check("rst_state", o_dbg_state, 0);
        i_rst_n = 1'b1;

        // table vectors, without and then with stalls / random status
        for (int pass = 0; pass < 2; pass++) begin
            wait_cycles = (pass == 0) ? 0 : 5;
            rand_status = (pass == 1);
            for (int i = 0; i < 5; i++)
                run_block(vecs[i].do_rst, vecs[i].send_key, vecs[i].spur, vecs[i].n, vecs[i].d,
                          256'(vecs[i].a), vecs[i].res);
        end

        // randomized keys and blocks
        for (int k = 0; k < 3; k++) begin
            wait_cycles = $urandom_range(0, 3);
            rn = $urandom_range(3, 65535);
            rd = $urandom_range(1, 65535);
            ra = $urandom_range(0, 32'(rn - 1));
            run_block(1'b1, 1'b1, 1'b0, rn, rd, 256'(ra), modexp(ra, rd, rn));
            ra = $urandom_range(0, 32'(rn - 1));
            run_block(1'b0, 1'b0, 1'b0, rn, rd, 256'(ra), modexp(ra, rd, rn));
        end

        // reset while the core is computing
        wait_cycles = 1;
        rand_status = 1'b0;
        core_delay  = 40;
        do_reset();
        s0 = start_cnt;
        t0 = tx_cnt;
        push_field(256'd33);
        push_field(256'd7);
        push_field(256'd2);
        cyc = 0;
        while (start_cnt == s0 && cyc < 5000) begin @(negedge i_clk); cyc++; end
        check("abort_started", start_cnt - s0, 1);
        repeat (5) @(negedge i_clk);
        do_reset();
        repeat (80) @(negedge i_clk);
        check("abort_no_tx", tx_cnt - t0, 0);
        check("abort_n_clr", o_rsa_n, 0);
        check("abort_addr", avm_address, 8);
        core_delay = 3;
        run_block(1'b0, 1'b1, 1'b0, 187, 3, 256'd10, 65);

        // all-ones cipher block
`ifdef RSA_KEY_RELOAD_EN
        s0 = start_cnt;
        t0 = tx_cnt;
        push_field({256{1'b1}});
        cyc = 0;
        while (rx_q.size() != 0 && cyc < 2000) begin @(negedge i_clk); cyc++; end
        repeat (100) @(negedge i_clk);
        check("reload_no_start", start_cnt - s0, 0);
        check("reload_no_tx", tx_cnt - t0, 0);
        check("reload_n_clr", o_rsa_n, 0);
        check("reload_a_clr", o_rsa_a, 0);
        run_block(1'b0, 1'b1, 1'b0, 35, 5, 256'd4, 9);
`else
        run_block(1'b0, 1'b0, 1'b0, 187, 3, {256{1'b1}}, modexp(reduce256({256{1'b1}}, 187), 3, 187));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
